// File: rtl/svm_stage_engine_if.sv
// svm_stage_engine_if: pixel stream, SV/alpha memory ports and result handshake of one SVM stage.
interface svm_stage_engine_if #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 784,
    parameter int NUM_OF_SV     = 87,
    parameter int LANES         = 4,
    parameter int ALPHA_W       = 16,
    parameter int SCORE_W       = 48
);
    localparam int WORDS = NUM_OF_PIXELS / LANES;
    localparam int AW    = (NUM_OF_SV * WORDS > 1) ? $clog2(NUM_OF_SV * WORDS) : 1;
    localparam int SIW   = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;
    logic                            pixel_valid;
    logic                            pixel_ready;
    logic [XLEN_PIXEL-1:0]           pixel_data;
    logic [AW-1:0]                   sv_addr;
    logic [LANES*XLEN_PIXEL-1:0]     sv_rdata;
    logic [SIW-1:0]                  alpha_addr;
    logic signed [ALPHA_W-1:0]       alpha_rdata;
    logic                            result_valid;
    logic                            result_ready;
    logic signed [SCORE_W-1:0]       score;
    logic                            y_class;
    logic                            confident;
    modport master (
        output pixel_valid, pixel_data, sv_rdata, alpha_rdata, result_ready,
        input  pixel_ready, sv_addr, alpha_addr, result_valid, score, y_class, confident
    );
    modport slave (
        input  pixel_valid, pixel_data, sv_rdata, alpha_rdata, result_ready,
        output pixel_ready, sv_addr, alpha_addr, result_valid, score, y_class, confident
    );
endinterface

// File: rtl/svm_stage_engine.sv
// svm_stage_engine: linear-kernel SVM stage, buffers one test vector, accumulates alpha-weighted dot products, saturates.
module svm_stage_engine #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 784,
    parameter int NUM_OF_SV     = 87,
    parameter int LANES         = 4,
    parameter int ALPHA_W       = 16,
    parameter int SCORE_W       = 48,
    parameter int CASCADE_EN    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic signed [SCORE_W-1:0] bias,
    input  logic [SCORE_W-2:0]        margin,
    svm_stage_engine_if.slave         bus
);
    localparam int WORDS = NUM_OF_PIXELS / LANES;
    localparam int AW    = (NUM_OF_SV * WORDS > 1) ? $clog2(NUM_OF_SV * WORDS) : 1;
    localparam int SIW   = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1;
    localparam int WW    = $clog2(WORDS + 1);
    localparam int PIW   = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
    localparam int DW    = 2 * XLEN_PIXEL + $clog2(NUM_OF_PIXELS);
    localparam int PW    = DW + 1 + ALPHA_W;
    localparam int EW    = ((PW > SCORE_W) ? PW : SCORE_W) + 2;
    localparam logic signed [EW-1:0] SMAX = {{(EW-SCORE_W+1){1'b0}}, {(SCORE_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SMIN = {{(EW-SCORE_W+1){1'b1}}, {(SCORE_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, KERNEL, DECIDE, DONE} state_t;

    state_t                    state, nxt;
    logic                      alive;
    logic [XLEN_PIXEL-1:0]     tbuf [NUM_OF_PIXELS];
    logic [PIW-1:0]            pix_idx;
    logic [AW-1:0]             addr;
    logic [SIW-1:0]            sv_idx;
    logic [WW-1:0]             word_idx;
    logic [PIW-1:0]            pbase;
    logic [DW-1:0]             dot, dot_next, lane_sum;
    logic signed [PW-1:0]      prod;
    logic signed [SCORE_W-1:0] acc, acc_next, fin, score_q;
    logic [SCORE_W-1:0]        mag;
    logic                      rv, y_q, conf_q, conf_d;
    logic                      pix_fire, last_word, last_sv, hs;

    function automatic logic signed [SCORE_W-1:0] sat(input logic signed [EW-1:0] v);
        return (v > SMAX) ? SMAX[SCORE_W-1:0] : (v < SMIN) ? SMIN[SCORE_W-1:0] : v[SCORE_W-1:0];
    endfunction

    // pixel_ready stays low until the first edge after reset release
    assign bus.pixel_ready  = alive && (state == IDLE || state == LOAD);
    assign bus.sv_addr      = addr;
    assign bus.alpha_addr   = sv_idx;
    assign bus.result_valid = rv;
    assign bus.score        = score_q;
    assign bus.y_class      = y_q;
    assign bus.confident    = conf_q;

    assign pix_fire  = bus.pixel_valid && bus.pixel_ready;
    assign last_word = word_idx == WW'(WORDS);
    assign last_sv   = sv_idx == SIW'(NUM_OF_SV - 1);
    assign hs        = rv && bus.result_ready;

    always_comb begin
        lane_sum = '0;
        for (int l = 0; l < LANES; l++)
            lane_sum = lane_sum + DW'(tbuf[pbase + PIW'(l)]) * DW'(bus.sv_rdata[l*XLEN_PIXEL +: XLEN_PIXEL]);
    end

    // the SV's last word arrives in the extra cycle, so the MAC uses dot_next directly
    assign dot_next = dot + lane_sum;
    assign prod     = $signed({1'b0, dot_next}) * bus.alpha_rdata;
    assign acc_next = sat(EW'(acc) + EW'(prod));
    assign fin      = sat(EW'(acc) + EW'(bias));
    assign mag      = fin[SCORE_W-1] ? -fin : fin;
    assign conf_d   = (CASCADE_EN == 0) || (mag >= {1'b0, margin});

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    nxt = pix_fire ? LOAD : IDLE;
            LOAD:    nxt = (pix_fire && pix_idx == PIW'(NUM_OF_PIXELS - 1)) ? KERNEL : LOAD;
            KERNEL:  nxt = (last_word && last_sv) ? DECIDE : KERNEL;
            DECIDE:  nxt = DONE;
            DONE:    nxt = hs ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
        if (clear)
            nxt = IDLE;
    end

    always_ff @(posedge clk)
        if (pix_fire)
            tbuf[pix_idx] <= bus.pixel_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            alive    <= 1'b0;
            pix_idx  <= '0;
            addr     <= '0;
            sv_idx   <= '0;
            word_idx <= '0;
            pbase    <= '0;
            dot      <= '0;
            acc      <= '0;
            rv       <= 1'b0;
            score_q  <= '0;
            y_q      <= 1'b0;
            conf_q   <= 1'b0;
        end else begin
            state   <= nxt;
            alive   <= 1'b1;
            pix_idx <= (clear || nxt == KERNEL) ? '0 : pix_fire ? pix_idx + 1'b1 : pix_idx;
            if (clear || state != KERNEL) begin
                addr     <= '0;
                sv_idx   <= '0;
                word_idx <= '0;
                pbase    <= '0;
                dot      <= '0;
            end else begin
                addr     <= last_word ? addr : addr + 1'b1;
                word_idx <= last_word ? '0 : word_idx + 1'b1;
                sv_idx   <= last_word ? sv_idx + 1'b1 : sv_idx;
                pbase    <= (last_word || word_idx == '0) ? '0 : pbase + PIW'(LANES);
                dot      <= (last_word || word_idx == '0) ? '0 : dot_next;
            end
            acc <= (clear || nxt == IDLE) ? '0 : (state == KERNEL && last_word) ? acc_next : acc;
            // valid follows DONE by one cycle so the result is already registered when raised
            rv  <= !clear && state == DONE && !hs;
            if (state == DECIDE && !clear) begin
                score_q <= fin;
                y_q     <= !fin[SCORE_W-1];
                conf_q  <= conf_d;
            end
        end
    end
endmodule
